// File: rtl/wiener_block_to_raster.sv
// wiener_block_to_raster: reorders block-order filtered pixels into a raster
// AXI4-Stream (tuser = start of frame, tlast = end of line) using two
// BLOCK_SIZE-line strip banks. Define WIENER_OUT_STATS_EN to add the
// frame_count / stall_cycles statistics outputs.
module wiener_block_to_raster #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 8,
    parameter int MAX_WIDTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           frame_width,
    input  logic [15:0]           frame_height,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  frame_done,
    output logic                  config_err
`ifdef WIENER_OUT_STATS_EN
    ,
    output logic [31:0]           frame_count,
    output logic [31:0]           stall_cycles
`endif
);
    localparam int LB = $clog2(BLOCK_SIZE);
    localparam int AW = $clog2(BLOCK_SIZE * MAX_WIDTH);

    // strip memory: bank bit on top of the in-bank address
    logic [DATA_WIDTH-1:0] r_mem [0:(2**(AW+1))-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // write side
    logic [LB-1:0] r_wc, r_wr;
    logic [15:0]   r_wbc, r_wsr, r_wm1, r_hm1;
    logic          r_wb, r_rb, r_cfg_err;
    logic [1:0]    r_full, r_bfirst, r_blast;
    logic [1:0][15:0] r_bwm1;

    // read side
    logic [15:0]   r_x;
    logic [LB-1:0] r_l;
    logic          r_s1_vld, r_s1_last, r_s1_user, r_s1_eof;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic          r_out_vld, r_out_last, r_out_user, r_out_eof, r_frame_done;

    logic          w_first, w_illegal, w_in_ready, w_hs, w_start, w_wr, w_strip_done;
    logic [15:0]   w_wm1, w_hm1, w_bcl, w_srl;
    logic [AW-1:0] w_waddr, w_raddr;
    logic          w_s1_adv, w_rd, w_xend, w_strip_rd_done;
    logic [1:0]    w_set, w_clr;

    // a new frame begins when the write counters sit at the origin
    assign w_first    = (r_wc == '0) && (r_wr == '0) && (r_wbc == '0) && (r_wsr == '0);
    assign w_illegal  = (frame_width == '0) || (frame_height == '0) ||
                        (|frame_width[LB-1:0]) || (|frame_height[LB-1:0]) ||
                        (frame_width > 16'(MAX_WIDTH));
    assign w_in_ready = !r_full[r_wb] && !r_cfg_err;
    assign w_hs       = in_valid && w_in_ready;
    assign w_start    = w_hs && w_first;
    // the first beat of an illegal frame is swallowed and never written
    assign w_wr       = w_hs && !(w_first && w_illegal);
    // geometry of the first beat comes straight from the inputs
    assign w_wm1      = w_first ? frame_width - 16'd1 : r_wm1;
    assign w_hm1      = w_first ? frame_height - 16'd1 : r_hm1;
    assign w_bcl      = w_wm1 >> LB;
    assign w_srl      = w_hm1 >> LB;
    assign w_strip_done = w_wr && (&r_wc) && (&r_wr) && (r_wbc == w_bcl);
    assign w_waddr    = AW'(32'(r_wr) * MAX_WIDTH + 32'({r_wbc, r_wc}));

    // read issues only when the stage-1 slot is free or moving on
    assign w_s1_adv   = !r_out_vld || m_axis_tready;
    assign w_rd       = r_full[r_rb] && (!r_s1_vld || w_s1_adv);
    assign w_xend     = (r_x == r_bwm1[r_rb]);
    assign w_strip_rd_done = w_rd && w_xend && (&r_l);
    assign w_raddr    = AW'(32'(r_l) * MAX_WIDTH + 32'(r_x));

    assign w_set = w_strip_done    ? (2'b01 << r_wb) : 2'b00;
    assign w_clr = w_strip_rd_done ? (2'b01 << r_rb) : 2'b00;

    // memory write and synchronous read (no reset on storage)
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[{r_wb, w_waddr}] <= in_data;
        if (w_rd) r_rdata <= r_mem[{r_rb, w_raddr}];
    end

    // write counters, geometry latch, bank tags and sticky config error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wc <= '0; r_wr <= '0; r_wbc <= '0; r_wsr <= '0;
            r_wm1 <= '0; r_hm1 <= '0; r_wb <= 1'b0; r_cfg_err <= 1'b0;
            r_bwm1 <= '0; r_bfirst <= '0; r_blast <= '0;
        end else begin
            if (w_start && w_illegal) r_cfg_err <= 1'b1;
            if (w_start) begin
                r_wm1 <= w_wm1;
                r_hm1 <= w_hm1;
            end
            if (w_wr) begin
                r_wc <= r_wc + 1'b1;
                if (&r_wc) begin
                    r_wr <= r_wr + 1'b1;
                    if (&r_wr) begin
                        if (r_wbc == w_bcl) begin
                            r_wbc <= '0;
                            r_wsr <= (r_wsr == w_srl) ? 16'd0 : r_wsr + 16'd1;
                        end else begin
                            r_wbc <= r_wbc + 16'd1;
                        end
                    end
                end
            end
            if (w_strip_done) begin
                r_wb           <= ~r_wb;
                r_bwm1[r_wb]   <= w_wm1;
                r_bfirst[r_wb] <= (r_wsr == '0);
                r_blast[r_wb]  <= (r_wsr == w_srl);
            end
        end
    end

    // bank full flags: set by writer, cleared by reader, always different banks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_full <= '0;
        else     r_full <= (r_full | w_set) & ~w_clr;
    end

    // read counters and stage-1 sideband that travels with the memory read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0; r_l <= '0; r_rb <= 1'b0;
            r_s1_vld <= 1'b0; r_s1_last <= 1'b0; r_s1_user <= 1'b0; r_s1_eof <= 1'b0;
        end else if (w_rd) begin
            r_s1_vld  <= 1'b1;
            r_s1_last <= w_xend;
            r_s1_user <= r_bfirst[r_rb] && (r_x == '0) && (r_l == '0);
            r_s1_eof  <= r_blast[r_rb] && w_xend && (&r_l);
            if (w_xend) begin
                r_x <= '0;
                r_l <= r_l + 1'b1;
                if (&r_l) r_rb <= ~r_rb;
            end else begin
                r_x <= r_x + 16'd1;
            end
        end else if (w_s1_adv) begin
            r_s1_vld <= 1'b0;
        end
    end

    // output register: holds its beat while the sink stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld <= 1'b0; r_tdata <= '0; r_out_last <= 1'b0;
            r_out_user <= 1'b0; r_out_eof <= 1'b0; r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= r_out_vld && m_axis_tready && r_out_eof;
            if (w_s1_adv) begin
                r_out_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_tdata    <= r_rdata;
                    r_out_last <= r_s1_last;
                    r_out_user <= r_s1_user;
                    r_out_eof  <= r_s1_eof;
                end
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_out_vld;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tuser  = r_out_user;
    assign frame_done    = r_frame_done;
    assign config_err    = r_cfg_err;

`ifdef WIENER_OUT_STATS_EN
    logic [31:0] r_frame_count, r_stall_cycles;

    // frame counter and per-frame output stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_count  <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (r_frame_done) r_frame_count <= r_frame_count + 32'd1;
            if (w_start)      r_stall_cycles <= '0;
            else if (r_out_vld && !m_axis_tready) r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign frame_count  = r_frame_count;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_wiener_block_to_raster.sv
// Scoreboard bench for wiener_block_to_raster: expected raster beats are
// queued when a frame is issued; a negedge monitor pops and compares.
module tb_wiener_block_to_raster;
    localparam int B = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] frame_width, frame_height;
    logic [31:0] in_data;
    logic        in_valid, in_ready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic        frame_done, config_err;
`ifdef WIENER_OUT_STATS_EN
    logic [31:0] frame_count, stall_cycles;
`endif

    wiener_block_to_raster #(.DATA_WIDTH(32), .BLOCK_SIZE(B), .MAX_WIDTH(256)) dut (
        .clk(clk), .rst(rst),
        .frame_width(frame_width), .frame_height(frame_height),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .frame_done(frame_done), .config_err(config_err)
`ifdef WIENER_OUT_STATS_EN
        , .frame_count(frame_count), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
        logic        user;
    } beat_t;

    beat_t sb[$];
    int n_chk = 0, n_pass = 0;
    int fd_cnt = 0, irl_valid = 0, irl_any = 0;
    int tr_mode = 0, stall_tok = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // monitor: compare the presented beat to the scoreboard head, pop on transfer
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (frame_done) fd_cnt++;
            if (!in_ready) irl_any++;
            if (in_valid && !in_ready) irl_valid++;
            if (m_axis_tvalid) begin
                if (sb.size() == 0) chk("unexpected_beat", 64'(m_axis_tvalid), 64'd0);
                else begin
                    chk("beat", 64'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 64'(sb[0]));
                    if (m_axis_tready) void'(sb.pop_front());
                end
            end
        end
    end

    // sink ready driver: 0 = always ready, 1 = toggle plus 3-cycle stalls, 3 = stall on request
    initial begin
        int hold;
        int seen;
        hold = 0;
        seen = 0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (tr_mode == 1) begin
                if (hold > 0) begin m_axis_tready = 1'b0; hold--; end
                else if ($urandom_range(0, 15) == 0) begin m_axis_tready = 1'b0; hold = 2; end
                else m_axis_tready = !m_axis_tready;
            end else if (tr_mode == 3) begin
                if (stall_tok != seen) begin seen = stall_tok; hold = 5; end
                if (hold > 0) begin m_axis_tready = 1'b0; hold--; end
                else m_axis_tready = 1'b1;
            end else begin
                hold = 0;
                m_axis_tready = 1'b1;
            end
        end
    end

    // expected raster sequence for a frame whose block-order input is base, base+1, ...
    task automatic push_frame(input int w, input int h, input int base);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                beat_t e;
                e.d    = 32'(base + (y / B) * w * B + (x / B) * B * B + (y % B) * B + (x % B));
                e.last = (x == w - 1);
                e.user = (y == 0) && (x == 0);
                sb.push_back(e);
            end
    endtask

    // drive beats in block order; n_max < 0 sends the whole frame
    task automatic send_frame(input int w, input int h, input int base, input int n_max);
        frame_width  = 16'(w);
        frame_height = 16'(h);
        for (int k = 0; k < w * h && (n_max < 0 || k < n_max); k++) begin
            logic acc;
            int   t;
            in_data  = 32'(base + k);
            in_valid = 1'b1;
            t = 0;
            acc = 1'b0;
            while (!acc && t < 2000) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) chk("in_ready_timeout", 64'(acc), 64'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 5000) begin @(posedge clk); t++; end
        chk("drain", 64'(sb.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata",  64'(m_axis_tdata),  64'd0);
        chk("rst_tlast",  64'(m_axis_tlast),  64'd0);
        chk("rst_tuser",  64'(m_axis_tuser),  64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_config_err", 64'(config_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int fd0, irl0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        frame_width = 16'd16;
        frame_height = 16'd16;
        do_reset();

        // 16x16, sink always ready
        fd0 = fd_cnt;
        push_frame(16, 16, 0);
        send_frame(16, 16, 0, -1);
        drain();
        chk("t1_frame_done", 64'(fd_cnt - fd0), 64'd1);

        // same frame with a stalling sink
        fd0 = fd_cnt; irl0 = irl_any;
        tr_mode = 1;
        push_frame(16, 16, 0);
        send_frame(16, 16, 0, -1);
        drain();
        tr_mode = 0;
        chk("t2_frame_done", 64'(fd_cnt - fd0), 64'd1);
        chk("t2_in_ready_dropped", 64'(irl_any - irl0 > 0), 64'd1);

        // two back-to-back 16x8 frames, input must never stall
        repeat (3) @(posedge clk); #1;
        fd0 = fd_cnt; irl0 = irl_valid;
        push_frame(16, 8, 100);
        push_frame(16, 8, 500);
        send_frame(16, 8, 100, -1);
        send_frame(16, 8, 500, -1);
        drain();
        chk("t3_frame_done", 64'(fd_cnt - fd0), 64'd2);
        chk("t3_no_input_stall", 64'(irl_valid - irl0), 64'd0);
        chk("t3_config_err", 64'(config_err), 64'd0);

        // illegal width 12: sticky error, no output
        frame_width = 16'd12;
        frame_height = 16'd16;
        in_data = 32'd7;
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t4_config_err", 64'(config_err), 64'd1);
        chk("t4_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        chk("t4_config_err_sticky", 64'(config_err), 64'd1);
        do_reset();

        // reset mid-frame, then a clean 8x8 frame
        send_frame(16, 16, 5000, 40);
        do_reset();
        fd0 = fd_cnt;
        push_frame(8, 8, 2000);
        send_frame(8, 8, 2000, -1);
        drain();
        chk("t5_frame_done", 64'(fd_cnt - fd0), 64'd1);

`ifdef WIENER_OUT_STATS_EN
        // three frames, exactly five stalled cycles in the last one
        do_reset();
        push_frame(8, 8, 3000);
        send_frame(8, 8, 3000, -1);
        push_frame(8, 8, 3100);
        send_frame(8, 8, 3100, -1);
        drain();
        tr_mode = 3;
        push_frame(8, 8, 3200);
        send_frame(8, 8, 3200, -1);
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!m_axis_tvalid && t < 100) begin @(negedge clk); t++; end
            chk("t6_tvalid_seen", 64'(m_axis_tvalid), 64'd1);
            stall_tok++;
        end
        drain();
        tr_mode = 0;
        chk("t6_frame_count", 64'(frame_count), 64'd3);
        chk("t6_stall_cycles", 64'(stall_cycles), 64'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/wiener_block_to_raster.md
# wiener_block_to_raster

Output stage directly downstream of the Wiener filter top. It accepts filtered pixels in block order: BLOCK_SIZE×BLOCK_SIZE blocks, raster over the block grid, raster inside each block. It reorders them through a double-buffered strip memory and emits a raster-order AXI4-Stream video output with start-of-frame on `m_axis_tuser` and end-of-line on `m_axis_tlast`. This lets the denoised frame leave the chip in the same format as the input stream.

## Interface
- `DATA_WIDTH`, 32: pixel word width (packed RGB, passed through untouched)
- `BLOCK_SIZE`, 8: block edge in pixels; power of 2
- `MAX_WIDTH`, 256: maximum frame width in pixels; sets strip depth to BLOCK_SIZE×MAX_WIDTH per bank
- `clk` input 1: clock
- `rst` input 1: asynchronous reset, active-high
- `frame_width` input 16: pixels per line; sampled at frame start
- `frame_height` input 16: lines per frame; sampled at frame start
- `in_data` input DATA_WIDTH: filtered pixel from Wiener stage
- `in_valid` input 1: `in_data` valid
- `in_ready` output 1: beat accepted when `in_valid & in_ready`
- `m_axis_tdata` output DATA_WIDTH: raster pixel
- `m_axis_tvalid` output 1: output beat valid
- `m_axis_tready` input 1: downstream ready
- `m_axis_tlast` output 1: last pixel of a line
- `m_axis_tuser` output 1: first pixel of a frame
- `frame_done` output 1: one-cycle pulse after the last pixel of a frame is accepted downstream
- `config_err` output 1: sticky; sampled geometry is illegal

## Operation
- Two strip banks (0/1), each holding BLOCK_SIZE lines × MAX_WIDTH pixels, each with a `full` flag. Write bank pointer `wb` and read bank pointer `rb` both reset to 0.
- Frame start occurs when all write counters are zero and the first beat arrives. At that point `frame_width`/`frame_height` are latched. Changes made mid-frame are ignored.
- Geometry is illegal if width or height is 0, is not a multiple of BLOCK_SIZE, or if width > MAX_WIDTH. On illegal geometry: `config_err`=1, `in_ready`=0 until reset, and no output.
- Write counters: `c`, `r` run 0..BLOCK_SIZE-1 (col/row inside block), `bc` runs 0..W/B-1, `sr` runs 0..H/B-1. Write address = r·MAX_WIDTH + bc·B + c in bank `wb`.
- `in_ready` = !full[wb] & !config_err. The accepted beat that completes the strip (last c, r, bc) sets full[wb] and toggles `wb`.
- Read counters: `x` runs 0..W-1 and `l` runs 0..B-1 in bank `rb` while full[rb]. At the end of a strip: clear full[rb], toggle `rb`, and advance the strip count. After the last strip, pulse `frame_done`.
- `m_axis_tlast` = (x==W-1). `m_axis_tuser` = first beat of strip 0, line 0.
- Set and clear of different banks in the same cycle are both applied. The same bank is never set and cleared in the same cycle.
- Frame height is unbounded by memory: strips recycle the two banks.

## Timing
- Reset values: `m_axis_tvalid`/`tlast`/`tuser`/`frame_done`/`config_err` = 0, `m_axis_tdata` = 0, full flags 0, all counters 0. `in_ready` = 1 once reset is applied, since it is combinational from the reset state.
- Memory read is synchronous, 1 cycle. `m_axis_tvalid` rises 2 cycles after the accepting edge of the strip's final input beat when the read bank is idle.
- Output register: while `tvalid & !tready`, `tdata`/`tlast`/`tuser` are held stable. No beat is lost or duplicated. Throughput is 1 beat/cycle with `tready` held high.
- Input and output run concurrently on opposite banks. With `tready` = 1 and continuous input, the input never stalls.
- `frame_done` pulses in the cycle after the last beat is accepted.
- Reset asserted mid-operation: everything returns to reset values immediately (async). Partial strips are discarded, and the next beat is treated as frame start.

## Configuration
- `WIENER_OUT_STATS_EN` defined: adds outputs `frame_count` (32 bit, increments on each `frame_done`) and `stall_cycles` (32 bit, counts cycles with `m_axis_tvalid & !m_axis_tready`; cleared at each frame start). Both reset to 0 and wrap on overflow.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- 16×16 frame, `in_data` = 0..255 in block order, `tready` = 1 → line 0 = 0..7, 64..71; line 1 = 8..15, 72..79. `tuser` only on value 0. `tlast` on 71, 79, …, 255. One `frame_done`.
- Same frame with `tready` toggling 1-0 and random 3-cycle stalls → identical 256-beat sequence, data stable during stalls, `in_ready` drops while both banks are full.
- Two back-to-back 16×8 frames with continuous input → `in_ready` never low, 2 `frame_done` pulses, `tuser` on the first beat of each frame.
- `frame_width` = 12 → `config_err` = 1 and `in_ready` = 0 after the first valid beat. No `tvalid` ever, until `rst`.
- Assert `rst` after 40 beats of a 16×16 frame, then send a full 8×8 frame → output is exactly that frame's 64 pixels with correct `tuser`/`tlast`.
- `WIENER_OUT_STATS_EN` defined: 3 frames with 5 stall cycles in the last frame → `frame_count` = 3, `stall_cycles` = 5.
